// File: rtl/writeback_unit_if.sv
// Execute / data-memory / register-file signal bundle for the writeback stage.
// The unit takes the slave view; execute, memory and the register file take the master view.
interface writeback_unit_if;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_reg_write;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_result;
  logic [2:0]  ex_load_funct3;
  logic [1:0]  ex_addr_lo;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        reg_write;
  logic [4:0]  write_index;
  logic [31:0] write_data;
  logic        pending_valid;
  logic [4:0]  pending_rd;
  logic        load_fault;

  modport slave (
    input  ex_valid, ex_reg_write, ex_is_load, ex_rd, ex_alu_result,
           ex_load_funct3, ex_addr_lo, mem_ready, mem_rdata,
    output ex_ready, reg_write, write_index, write_data,
           pending_valid, pending_rd, load_fault
  );

  modport master (
    output ex_valid, ex_reg_write, ex_is_load, ex_rd, ex_alu_result,
           ex_load_funct3, ex_addr_lo, mem_ready, mem_rdata,
    input  ex_ready, reg_write, write_index, write_data,
           pending_valid, pending_rd, load_fault
  );
endinterface

// File: rtl/writeback_unit.sv
// Final pipeline stage: registers ALU results and extracted load data into the
// register-file write port, and aborts loads whose memory response never arrives.
//
// state    | meaning
// IDLE     | accepting instructions from execute
// WAIT_MEM | load outstanding, waiting for mem_ready or timeout
module writeback_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic       CLK,
  input logic       nRST,
  writeback_unit_if.slave wb
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_MEM = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [0:0]  state;
  logic [7:0]  cnt;
  logic [4:0]  lat_rd;
  logic [2:0]  lat_f3;
  logic [1:0]  lat_lo;
  logic        lat_en;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;

  assign wb.ex_ready      = (state == IDLE);
  assign wb.pending_valid = (state == WAIT_MEM);
  assign wb.pending_rd    = (state == WAIT_MEM) ? lat_rd : 5'd0;

  always_comb begin
    byte_v    = 8'd0;
    half_v    = wb.mem_rdata[15:0];
    load_data = wb.mem_rdata;
    case (lat_lo)
      2'd0: byte_v = wb.mem_rdata[7:0];
      2'd1: byte_v = wb.mem_rdata[15:8];
      2'd2: byte_v = wb.mem_rdata[23:16];
      2'd3: byte_v = wb.mem_rdata[31:24];
      default: byte_v = 8'd0;
    endcase
    if (lat_lo[1]) half_v = wb.mem_rdata[31:16];
    // Undefined funct3 encodings fall through to a plain word load.
    case (lat_f3)
      3'b000: load_data = {{24{byte_v[7]}}, byte_v};
      3'b001: load_data = {{16{half_v[15]}}, half_v};
      3'b100: load_data = {24'd0, byte_v};
      3'b101: load_data = {16'd0, half_v};
      default: load_data = wb.mem_rdata;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      lat_rd         <= 5'd0;
      lat_f3         <= 3'd0;
      lat_lo         <= 2'd0;
      lat_en         <= 1'b0;
      wb.reg_write   <= 1'b0;
      wb.write_index <= 5'd0;
      wb.write_data  <= 32'd0;
      wb.load_fault  <= 1'b0;
    end else begin
      wb.reg_write  <= 1'b0;
      wb.load_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (wb.ex_valid) begin
            if (wb.ex_is_load) begin
              lat_rd <= wb.ex_rd;
              lat_f3 <= wb.ex_load_funct3;
              lat_lo <= wb.ex_addr_lo;
              lat_en <= wb.ex_reg_write && (wb.ex_rd != 5'd0);
              cnt    <= 8'd0;
              state  <= WAIT_MEM;
            end else begin
              wb.reg_write   <= wb.ex_reg_write && (wb.ex_rd != 5'd0);
              wb.write_index <= wb.ex_rd;
              wb.write_data  <= wb.ex_alu_result;
            end
          end
        end
        WAIT_MEM: begin
          // A response on the final counted cycle still completes normally.
          if (wb.mem_ready) begin
            wb.reg_write   <= lat_en;
            wb.write_index <= lat_rd;
            wb.write_data  <= load_data;
            cnt            <= 8'd0;
            state          <= IDLE;
          end else if (cnt == CNT_LAST) begin
            wb.load_fault <= 1'b1;
            cnt           <= 8'd0;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: expected register writes are queued at
// issue and matched against every reg_write pulse seen on the write port.
module tb_writeback_unit;

  logic CLK;
  logic nRST;
  writeback_unit_if wb ();

  writeback_unit #(.TIMEOUT_CYCLES(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .wb   (wb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  faults_seen = 0;
  int  faults_exp = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((w >> (8 * lo)) & 32'hFF);
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Write-port monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (wb.load_fault === 1'b1) faults_seen++;
    if (wb.reg_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, wb.write_index}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_index", {27'd0, wb.write_index}, {27'd0, e.idx});
        chk("write_data", wb.write_data, e.data);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    wb.ex_valid       = 1'b0;
    wb.ex_reg_write   = 1'b0;
    wb.ex_is_load     = 1'b0;
    wb.ex_rd          = 5'd0;
    wb.ex_alu_result  = 32'd0;
    wb.ex_load_funct3 = 3'd0;
    wb.ex_addr_lo     = 2'd0;
    wb.mem_ready      = 1'b0;
    wb.mem_rdata      = 32'h5A5A_A5A5;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] val, input logic we);
    chk("alu_ex_ready", {31'd0, wb.ex_ready}, 32'd1);
    wb.ex_valid      = 1'b1;
    wb.ex_is_load    = 1'b0;
    wb.ex_reg_write  = we;
    wb.ex_rd         = rd;
    wb.ex_alu_result = val;
    if (we && rd != 5'd0) exp_q.push_back('{idx: rd, data: val});
    cyc();
    idle_inputs();
  endtask

  // wait_cycles = number of WAIT_MEM cycles including the one with mem_ready high.
  task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                      input logic [31:0] word, input int wait_cycles);
    chk("ld_ex_ready", {31'd0, wb.ex_ready}, 32'd1);
    wb.ex_valid       = 1'b1;
    wb.ex_is_load     = 1'b1;
    wb.ex_reg_write   = 1'b1;
    wb.ex_rd          = rd;
    wb.ex_load_funct3 = f3;
    wb.ex_addr_lo     = lo;
    wb.ex_alu_result  = 32'hBAD0_0BAD;
    if (rd != 5'd0) exp_q.push_back('{idx: rd, data: model_load(f3, lo, word)});
    cyc();
    idle_inputs();
    for (int i = 0; i < wait_cycles; i++) begin
      chk("wait_pending_valid", {31'd0, wb.pending_valid}, 32'd1);
      chk("wait_ex_ready", {31'd0, wb.ex_ready}, 32'd0);
      chk("wait_pending_rd", {27'd0, wb.pending_rd}, {27'd0, rd});
      chk("wait_reg_write", {31'd0, wb.reg_write}, 32'd0);
      if (i == wait_cycles - 1) begin
        wb.mem_ready = 1'b1;
        wb.mem_rdata = word;
      end
      cyc();
    end
    wb.mem_ready = 1'b0;
    chk("done_ex_ready", {31'd0, wb.ex_ready}, 32'd1);
    chk("done_pending_valid", {31'd0, wb.pending_valid}, 32'd0);
    chk("done_load_fault", {31'd0, wb.load_fault}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    nRST = 1'b0;
    cyc();
    cyc();
    chk("rst_reg_write", {31'd0, wb.reg_write}, 32'd0);
    chk("rst_write_index", {27'd0, wb.write_index}, 32'd0);
    chk("rst_write_data", wb.write_data, 32'd0);
    chk("rst_load_fault", {31'd0, wb.load_fault}, 32'd0);
    chk("rst_pending_valid", {31'd0, wb.pending_valid}, 32'd0);
    nRST = 1'b1;
    cyc();

    // mem_ready in IDLE must not cause a write
    wb.mem_ready = 1'b1;
    wb.mem_rdata = 32'h1111_2222;
    cyc();
    idle_inputs();

    // ALU path, then hold of index/data on idle cycle
    alu(5'd5, 32'hDEAD_BEEF, 1'b1);
    cyc();
    chk("alu_idle_reg_write", {31'd0, wb.reg_write}, 32'd0);
    chk("alu_hold_index", {27'd0, wb.write_index}, 32'd5);
    chk("alu_hold_data", wb.write_data, 32'hDEAD_BEEF);

    // back-to-back ALU writes, x0 suppression, reg_write=0 and zero data
    alu(5'd1, 32'h0000_0001, 1'b1);
    alu(5'd31, 32'hFFFF_FFFF, 1'b1);
    alu(5'd0, 32'h0000_1234, 1'b1);
    chk("x0_reg_write", {31'd0, wb.reg_write}, 32'd0);
    alu(5'd6, 32'h0000_5555, 1'b0);
    chk("nowe_reg_write", {31'd0, wb.reg_write}, 32'd0);
    alu(5'd7, 32'd0, 1'b1);
    chk("zero_data_reg_write", {31'd0, wb.reg_write}, 32'd1);
    cyc();

    // load extraction with a 3-cycle memory response
    load(5'd10, 3'b000, 2'd0, 32'h80F0_7F81, 3);
    load(5'd11, 3'b100, 2'd1, 32'h80F0_7F81, 3);
    load(5'd12, 3'b001, 2'd2, 32'h80F0_7F81, 3);
    load(5'd13, 3'b101, 2'd2, 32'h80F0_7F81, 3);
    load(5'd14, 3'b010, 2'd3, 32'h80F0_7F81, 3);
    load(5'd15, 3'b000, 2'd3, 32'h80F0_7F81, 1);
    load(5'd16, 3'b001, 2'd1, 32'h7FFF_8000, 2);
    load(5'd17, 3'b110, 2'd1, 32'h1234_5678, 1);
    // load to x0 still waits, then writes nothing
    load(5'd0, 3'b010, 2'd0, 32'hCAFE_F00D, 3);
    chk("ldx0_reg_write", {31'd0, wb.reg_write}, 32'd0);
    cyc();

    // timeout: mem_ready never arrives
    chk("to_ex_ready", {31'd0, wb.ex_ready}, 32'd1);
    wb.ex_valid       = 1'b1;
    wb.ex_is_load     = 1'b1;
    wb.ex_reg_write   = 1'b1;
    wb.ex_rd          = 5'd9;
    wb.ex_load_funct3 = 3'b010;
    cyc();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("to_no_fault_yet", {31'd0, wb.load_fault}, 32'd0);
      chk("to_pending_valid", {31'd0, wb.pending_valid}, 32'd1);
    end
    cyc();
    faults_exp++;
    chk("to_fault", {31'd0, wb.load_fault}, 32'd1);
    chk("to_reg_write", {31'd0, wb.reg_write}, 32'd0);
    chk("to_ex_ready_after", {31'd0, wb.ex_ready}, 32'd1);
    cyc();
    chk("to_fault_one_cycle", {31'd0, wb.load_fault}, 32'd0);

    // mem_ready on the timeout cycle wins
    load(5'd9, 3'b010, 2'd0, 32'h0BAD_CAFE, 4);
    chk("edge_reg_write", {31'd0, wb.reg_write}, 32'd1);
    cyc();

    // reset in WAIT_MEM discards the load
    wb.ex_valid       = 1'b1;
    wb.ex_is_load     = 1'b1;
    wb.ex_reg_write   = 1'b1;
    wb.ex_rd          = 5'd20;
    wb.ex_load_funct3 = 3'b010;
    cyc();
    idle_inputs();
    chk("prerst_pending", {31'd0, wb.pending_valid}, 32'd1);
    nRST = 1'b0;
    cyc();
    nRST = 1'b1;
    chk("mrst_reg_write", {31'd0, wb.reg_write}, 32'd0);
    chk("mrst_write_index", {27'd0, wb.write_index}, 32'd0);
    chk("mrst_write_data", wb.write_data, 32'd0);
    chk("mrst_load_fault", {31'd0, wb.load_fault}, 32'd0);
    chk("mrst_pending_valid", {31'd0, wb.pending_valid}, 32'd0);
    chk("mrst_pending_rd", {27'd0, wb.pending_rd}, 32'd0);
    chk("mrst_ex_ready", {31'd0, wb.ex_ready}, 32'd1);
    wb.mem_ready = 1'b1;
    wb.mem_rdata = 32'hFEED_FACE;
    cyc();
    idle_inputs();
    chk("postrst_reg_write", {31'd0, wb.reg_write}, 32'd0);
    for (int i = 0; i < 6; i++) cyc();
    chk("postrst_no_fault", {31'd0, wb.load_fault}, 32'd0);

    // final ALU after reset recovery
    alu(5'd3, 32'hA5A5_0F0F, 1'b1);
    cyc();
    cyc();

    chk("sb_remaining", exp_q.size(), 32'd0);
    chk("fault_count", faults_seen, faults_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage of the RISC-V core; drives the register file write port (reg_write, write_index, write_data).
- Accepts retired ALU results and load requests from execute.
- For loads, waits on the data-memory response, then byte/half/word-extracts and sign/zero-extends the data.
- Exposes pending-load destination info to the hazard unit and flags memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 64, WAIT_MEM cycles without mem_ready before the load is aborted; legal range 2..255.

Ports:
- CLK  input  1  core clock, all state on rising edge
- nRST  input  1  synchronous active-low reset
- ex_valid  input  1  execute presents an instruction this cycle
- ex_ready  output  1  unit accepts the instruction (handshake = ex_valid & ex_ready)
- ex_reg_write  input  1  instruction writes rd
- ex_is_load  input  1  instruction is a load
- ex_rd  input  5  destination register index
- ex_alu_result  input  32  ALU result (non-load)
- ex_load_funct3  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ex_addr_lo  input  2  low two bits of the load address
- mem_ready  input  1  data-memory response valid this cycle
- mem_rdata  input  32  aligned memory word
- reg_write  output  1  register-file write enable (registered)
- write_index  output  5  register-file write index (registered)
- write_data  output  32  register-file write data (registered)
- pending_valid  output  1  a load is outstanding
- pending_rd  output  5  rd of the outstanding load
- load_fault  output  1  one-cycle pulse on load timeout

Behaviour:
- Reset: synchronous. On CLK with nRST=0, all outputs are 0, the FSM goes to IDLE and the timeout counter is 0. Reset mid-load discards the load with no write and no fault pulse.
- FSM states:
  - IDLE: ex_ready=1.
  - WAIT_MEM: ex_ready=0, pending_valid=1, pending_rd=latched rd.
  - Both outputs are combinational from state.
- IDLE, handshake with ex_is_load=0:
  - Next cycle: reg_write=ex_reg_write & (ex_rd!=0), write_index=ex_rd, write_data=ex_alu_result.
  - One-cycle latency; stay in IDLE.
  - Back-to-back ALU instructions give one write per cycle.
- IDLE, handshake with ex_is_load=1:
  - Latch rd, funct3, addr_lo and the write-enable (ex_reg_write & rd!=0).
  - Go to WAIT_MEM; counter=0; reg_write=0 next cycle.
  - The load always waits for memory, even when rd=0 or ex_reg_write=0.
- No handshake: reg_write=0 next cycle. write_index and write_data hold their last values.
- WAIT_MEM with mem_ready=1:
  - Next cycle: reg_write=latched enable, write_index=latched rd, write_data=extracted value.
  - Return to IDLE; new handshakes are accepted from that cycle.
- WAIT_MEM with mem_ready=0: counter increments.
- Timeout: when the counter reaches TIMEOUT_CYCLES-1 with mem_ready=0:
  - Next cycle: load_fault=1 for one cycle, reg_write=0, FSM to IDLE.
  - mem_ready=1 on that same cycle wins (normal completion, no fault).
- Load extraction:
  - Byte lane = addr_lo, bits [8*addr_lo+7 : 8*addr_lo].
  - Half lane = addr_lo[1], bits [16*addr_lo[1]+15 : 16*addr_lo[1]]; addr_lo[0] ignored.
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
  - LW, and the undefined encodings 011/110/111, return mem_rdata unchanged with addr_lo ignored.
- Writes to x0: reg_write is never asserted when write_index=0.
- Write data of 0 is a legal write: reg_write=1 with write_data=0.
- mem_ready in IDLE is ignored.

Test Plan:
- ALU path: handshake rd=5, alu=0xDEADBEEF, reg_write=1 -> next cycle reg_write=1, write_index=5, write_data=0xDEADBEEF; following cycle reg_write=0.
- Load extraction, mem_rdata=0x80F0_7F81:
  - LB addr_lo=0 -> write_data 0xFFFFFF81.
  - LBU addr_lo=1 -> 0x0000007F.
  - LH addr_lo=2 -> 0xFFFF80F0.
  - LHU addr_lo=2 -> 0x000080F0.
  - LW -> 0x80F07F81.
  - Each completes with mem_ready delayed by 3 cycles; pending_valid=1 and ex_ready=0 throughout the wait.
- x0 and zero data:
  - ALU with rd=0, alu=0x1234 -> reg_write stays 0.
  - LW rd=0 -> unit still waits for mem_ready, then reg_write=0.
  - ALU rd=7, alu=0 -> reg_write=1, write_data=0.
- Timeout, TIMEOUT_CYCLES=4, LW rd=9, mem_ready held 0 -> load_fault pulses once after 4 WAIT_MEM cycles; reg_write=0; ex_ready=1 the following cycle.
- Timeout edge: mem_ready=1 exactly on the timeout cycle -> normal write of rd=9, load_fault=0.
- Reset: nRST=0 for one cycle while in WAIT_MEM -> next cycle all outputs 0, FSM in IDLE. A subsequent mem_ready=1 causes no write.
